// File: rtl/fb_port_arbiter_pkg.sv
// Shared types for the framebuffer port arbiter.
// Owner encodings and small helpers used by the top level.
package fb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_VGA   = 2'd1,
    OWN_CPU   = 2'd2,
    OWN_STEAL = 2'd3
  } owner_e;

  function automatic logic issues_cmd(
    input owner_e own
  );
    return (own == OWN_CPU) || (own == OWN_STEAL);
  endfunction

endpackage

// File: rtl/fb_cmd_fifo.sv
// In-order command queue for processor framebuffer commands.
// Extra pointer MSB separates full from empty.
module fb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: scan-out first,
// queued CPU commands in free cycles, with a starvation steal.
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              vga_rd_en,
  input  logic [ADDR_W-1:0] vga_address,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rdata_valid,
  output logic              vga_underrun,
  input  logic              cpu_cmd_valid,
  output logic              cpu_cmd_ready,
  input  logic              cpu_cmd_we,
  input  logic [ADDR_W-1:0] cpu_cmd_addr,
  input  logic [DATA_W-1:0] cpu_cmd_wdata,
  output logic              cpu_rd_valid,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam int CW = 1 + ADDR_W + DATA_W;
  localparam int SW = (STARVE_LIMIT > 0) ?
                      $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  cmd_t              push_cmd;
  cmd_t              head;
  logic [CW-1:0]     head_raw;
  logic              full;
  logic              empty;
  logic              push;
  logic              issue;
  logic              steal_ok;
  owner_e            owner;
  logic [SW-1:0]     starve_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              tag_vga;
  logic              tag_cpu;

  assign push_cmd      = {cpu_cmd_we, cpu_cmd_addr, cpu_cmd_wdata};
  assign cpu_cmd_ready = !full;
  assign push          = cpu_cmd_valid && !full;
  assign head          = cmd_t'(head_raw);

  fb_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk   (clock),
    .rst_n (resetn),
    .push  (push),
    .wdata (push_cmd),
    .pop   (issue),
    .rdata (head_raw),
    .full  (full),
    .empty (empty)
  );

  assign steal_ok = (STARVE_LIMIT != 0) && !empty &&
                    (starve_cnt == LIMIT);

  always_comb begin
    owner = OWN_IDLE;
    priority case (1'b1)
      steal_ok:  owner = OWN_STEAL;
      vga_rd_en: owner = OWN_VGA;
      !empty:    owner = OWN_CPU;
      default:   owner = OWN_IDLE;
    endcase
  end

  assign issue = issues_cmd(owner);

  always_comb begin
    mem_addr  = last_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (owner == OWN_VGA) begin
      mem_addr = vga_address;
    end else if (issue) begin
      mem_addr  = head.addr;
      mem_we    = head.we;
      mem_wdata = head.wdata;
    end
  end

  // Idle cycles park the RAM address on the last one driven.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_addr <= '0;
    end else begin
      last_addr <= mem_addr;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (empty || issue) begin
      starve_cnt <= '0;
    end else if (owner == OWN_VGA && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tag_vga      <= 1'b0;
      tag_cpu      <= 1'b0;
      cpu_rd_valid <= 1'b0;
      cpu_rd_data  <= '0;
      vga_underrun <= 1'b0;
    end else begin
      tag_vga      <= (owner == OWN_VGA);
      tag_cpu      <= issue && !head.we;
      cpu_rd_valid <= tag_cpu;
      if (tag_cpu) cpu_rd_data <= mem_rdata;
      if (owner == OWN_STEAL && vga_rd_en) begin
        vga_underrun <= 1'b1;
      end
    end
  end

  assign vga_rdata_valid = tag_vga;
  assign vga_rdata       = tag_vga ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: one DUT with a steal
// limit of 8 and one with stealing disabled, each with its own RAM.
module tb_fb_port_arbiter;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        vga_rd_en = 1'b0;
  logic [18:0] vga_address = '0;
  logic        cpu_cmd_valid = 1'b0;
  logic        cpu_cmd_we = 1'b0;
  logic [18:0] cpu_cmd_addr = '0;
  logic [7:0]  cpu_cmd_wdata = '0;

  logic [7:0]  vga_rdata_a, vga_rdata_b;
  logic        vga_rdata_valid_a, vga_rdata_valid_b;
  logic        vga_underrun_a, vga_underrun_b;
  logic        cpu_cmd_ready_a, cpu_cmd_ready_b;
  logic        cpu_rd_valid_a, cpu_rd_valid_b;
  logic [7:0]  cpu_rd_data_a, cpu_rd_data_b;
  logic [18:0] mem_addr_a, mem_addr_b;
  logic        mem_we_a, mem_we_b;
  logic [7:0]  mem_wdata_a, mem_wdata_b;
  logic [7:0]  mem_rdata_a = '0;
  logic [7:0]  mem_rdata_b = '0;

  logic [7:0]  ram_a [logic [18:0]];
  logic [7:0]  ram_b [logic [18:0]];

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  fb_port_arbiter #(.STARVE_LIMIT(8)) u_a (
    .clock(clock), .resetn(resetn),
    .vga_rd_en(vga_rd_en), .vga_address(vga_address),
    .vga_rdata(vga_rdata_a), .vga_rdata_valid(vga_rdata_valid_a),
    .vga_underrun(vga_underrun_a),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready_a),
    .cpu_cmd_we(cpu_cmd_we), .cpu_cmd_addr(cpu_cmd_addr),
    .cpu_cmd_wdata(cpu_cmd_wdata),
    .cpu_rd_valid(cpu_rd_valid_a), .cpu_rd_data(cpu_rd_data_a),
    .mem_addr(mem_addr_a), .mem_we(mem_we_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  fb_port_arbiter #(.STARVE_LIMIT(0)) u_b (
    .clock(clock), .resetn(resetn),
    .vga_rd_en(vga_rd_en), .vga_address(vga_address),
    .vga_rdata(vga_rdata_b), .vga_rdata_valid(vga_rdata_valid_b),
    .vga_underrun(vga_underrun_b),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready_b),
    .cpu_cmd_we(cpu_cmd_we), .cpu_cmd_addr(cpu_cmd_addr),
    .cpu_cmd_wdata(cpu_cmd_wdata),
    .cpu_rd_valid(cpu_rd_valid_b), .cpu_rd_data(cpu_rd_data_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Registered-output RAMs, read-before-write.
  always @(posedge clock) begin
    mem_rdata_a <= ram_a.exists(mem_addr_a) ? ram_a[mem_addr_a] : 8'h00;
    if (mem_we_a) ram_a[mem_addr_a] = mem_wdata_a;
    mem_rdata_b <= ram_b.exists(mem_addr_b) ? ram_b[mem_addr_b] : 8'h00;
    if (mem_we_b) ram_b[mem_addr_b] = mem_wdata_b;
  end

  task automatic nc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    vga_rd_en     = 1'b0;
    vga_address   = '0;
    cpu_cmd_valid = 1'b0;
    cpu_cmd_we    = 1'b0;
    cpu_cmd_addr  = '0;
    cpu_cmd_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    #3;
    n_total++;
    if (cpu_cmd_ready_a !== 1'b1) $display("FAIL reset_ready: got %b exp 1", cpu_cmd_ready_a);
    else n_pass++;
    n_total++;
    if ({mem_we_a, mem_addr_a, mem_wdata_a} !== 28'h0)
      $display("FAIL reset_mem: got we=%b a=%h d=%h exp 0", mem_we_a, mem_addr_a, mem_wdata_a);
    else n_pass++;
    n_total++;
    if ({cpu_rd_valid_a, cpu_rd_data_a, vga_rdata_valid_a, vga_rdata_a, vga_underrun_a} !== 19'h0)
      $display("FAIL reset_outs: got rv=%b rd=%h vv=%b vd=%h un=%b exp 0",
               cpu_rd_valid_a, cpu_rd_data_a, vga_rdata_valid_a, vga_rdata_a, vga_underrun_a);
    else n_pass++;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    do_reset();
    cpu_cmd_valid = 1'b1; cpu_cmd_we = 1'b1;
    cpu_cmd_addr = 19'h00100; cpu_cmd_wdata = 8'h2A;
    #1;
    n_total++;
    if (mem_we_a !== 1'b0) $display("FAIL wr_empty_we: got %b exp 0", mem_we_a);
    else n_pass++;
    nc();
    cpu_cmd_we = 1'b0;
    #1;
    n_total++;
    if (mem_we_a !== 1'b1 || mem_addr_a !== 19'h00100 || mem_wdata_a !== 8'h2A)
      $display("FAIL wr_issue: got we=%b a=%h d=%h exp 1/00100/2a", mem_we_a, mem_addr_a, mem_wdata_a);
    else n_pass++;
    nc();
    cpu_cmd_valid = 1'b0;
    #1;
    n_total++;
    if (mem_we_a !== 1'b0 || mem_addr_a !== 19'h00100)
      $display("FAIL rd_issue: got we=%b a=%h exp 0/00100", mem_we_a, mem_addr_a);
    else n_pass++;
    nc();
    n_total++;
    if (cpu_rd_valid_a !== 1'b0) $display("FAIL rd_early: got %b exp 0", cpu_rd_valid_a);
    else n_pass++;
    nc();
    n_total++;
    if (cpu_rd_valid_a !== 1'b1 || cpu_rd_data_a !== 8'h2A)
      $display("FAIL rd_data: got v=%b d=%h exp 1/2a", cpu_rd_valid_a, cpu_rd_data_a);
    else n_pass++;
    nc();
    n_total++;
    if (cpu_rd_valid_a !== 1'b0) $display("FAIL rd_pulse: got %b exp 0", cpu_rd_valid_a);
    else n_pass++;
  endtask

  task automatic test_vga_priority();
    int bad;
    bad = 0;
    do_reset();
    vga_address = 19'h01234;
    for (int i = 0; i < 4; i++) begin
      vga_rd_en = 1'b1;
      cpu_cmd_valid = 1'b1; cpu_cmd_we = 1'b1;
      cpu_cmd_addr = 19'h00200 + 19'(i);
      cpu_cmd_wdata = 8'h10 + 8'(i);
      #1;
      if (mem_we_b) bad++;
      nc();
    end
    cpu_cmd_addr = 19'h002FF; cpu_cmd_wdata = 8'hFF;
    #1;
    n_total++;
    if (cpu_cmd_ready_b !== 1'b0) $display("FAIL full_ready: got %b exp 0", cpu_cmd_ready_b);
    else n_pass++;
    for (int j = 0; j < 6; j++) begin
      #1;
      if (mem_we_b !== 1'b0 || vga_rdata_valid_b !== 1'b1 || mem_addr_b !== 19'h01234) bad++;
      nc();
    end
    n_total++;
    if (bad != 0) $display("FAIL vga_block: got %0d bad cycles exp 0", bad);
    else n_pass++;
    vga_rd_en = 1'b0; cpu_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if (mem_we_b !== 1'b1 || mem_addr_b !== 19'h00200 + 19'(i) || mem_wdata_b !== 8'h10 + 8'(i))
        $display("FAIL drain_%0d: got we=%b a=%h d=%h exp 1/%h/%h", i,
                 mem_we_b, mem_addr_b, mem_wdata_b, 19'h00200 + 19'(i), 8'h10 + 8'(i));
      else n_pass++;
      nc();
    end
    #1;
    n_total++;
    if (mem_we_b !== 1'b0 || cpu_cmd_ready_b !== 1'b1)
      $display("FAIL drain_end: got we=%b rdy=%b exp 0/1", mem_we_b, cpu_cmd_ready_b);
    else n_pass++;
  endtask

  task automatic test_steal();
    int bad;
    bad = 0;
    do_reset();
    vga_rd_en = 1'b1; vga_address = 19'h02222;
    cpu_cmd_valid = 1'b1; cpu_cmd_we = 1'b1;
    cpu_cmd_addr = 19'h00300; cpu_cmd_wdata = 8'h77;
    nc();
    cpu_cmd_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      #1;
      if (mem_we_a) bad++;
      nc();
    end
    n_total++;
    if (bad != 0) $display("FAIL steal_early: got %0d writes exp 0", bad);
    else n_pass++;
    #1;
    n_total++;
    if (mem_we_a !== 1'b1 || mem_addr_a !== 19'h00300 || vga_underrun_a !== 1'b0)
      $display("FAIL steal_issue: got we=%b a=%h un=%b exp 1/00300/0", mem_we_a, mem_addr_a, vga_underrun_a);
    else n_pass++;
    nc();
    n_total++;
    if (vga_underrun_a !== 1'b1 || vga_rdata_valid_a !== 1'b0 || mem_addr_a !== 19'h02222)
      $display("FAIL steal_after: got un=%b vv=%b a=%h exp 1/0/02222",
               vga_underrun_a, vga_rdata_valid_a, mem_addr_a);
    else n_pass++;
    nc();
    n_total++;
    if (vga_rdata_valid_a !== 1'b1 || vga_underrun_a !== 1'b1)
      $display("FAIL steal_resume: got vv=%b un=%b exp 1/1", vga_rdata_valid_a, vga_underrun_a);
    else n_pass++;
  endtask

  task automatic test_full_drain();
    int bad;
    int off;
    logic acc;
    bad = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vga_rd_en = 1'b1;
      cpu_cmd_valid = 1'b1; cpu_cmd_we = 1'b1;
      cpu_cmd_addr = 19'h00400 + 19'(i);
      cpu_cmd_wdata = 8'h40 + 8'(i);
      nc();
    end
    vga_rd_en = 1'b0;
    off = 4;
    for (int k = 0; k < 8; k++) begin
      cpu_cmd_valid = (off < 8);
      cpu_cmd_addr  = 19'h00400 + 19'(off);
      cpu_cmd_wdata = 8'h40 + 8'(off);
      #1;
      if (k == 0) begin
        n_total++;
        if (cpu_cmd_ready_a !== 1'b0) $display("FAIL fd_full: got %b exp 0", cpu_cmd_ready_a);
        else n_pass++;
      end
      if (k == 1) begin
        n_total++;
        if (cpu_cmd_ready_a !== 1'b1) $display("FAIL fd_reready: got %b exp 1", cpu_cmd_ready_a);
        else n_pass++;
      end
      if (mem_we_a !== 1'b1 || mem_addr_a !== 19'h00400 + 19'(k) || mem_wdata_a !== 8'h40 + 8'(k))
        bad++;
      acc = cpu_cmd_valid && cpu_cmd_ready_a;
      nc();
      if (acc) off++;
    end
    cpu_cmd_valid = 1'b0;
    n_total++;
    if (bad != 0 || off != 8) $display("FAIL fd_order: got bad=%0d accepted=%0d exp 0/8", bad, off);
    else n_pass++;
    #1;
    n_total++;
    if (mem_we_a !== 1'b0) $display("FAIL fd_dup: got %b exp 0", mem_we_a);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    int bad;
    bad = 0;
    do_reset();
    cpu_cmd_valid = 1'b1; cpu_cmd_we = 1'b0; cpu_cmd_addr = 19'h00100;
    nc();
    cpu_cmd_we = 1'b1; cpu_cmd_addr = 19'h00500; cpu_cmd_wdata = 8'h55;
    nc();
    cpu_cmd_valid = 1'b0;
    resetn = 1'b0;
    #1;
    n_total++;
    if ({cpu_rd_valid_a, cpu_rd_data_a, mem_we_a, mem_addr_a, mem_wdata_a,
         vga_rdata_valid_a, vga_rdata_a, vga_underrun_a} !== 47'h0 || cpu_cmd_ready_a !== 1'b1)
      $display("FAIL mid_reset_outs: got rv=%b rd=%h we=%b a=%h rdy=%b exp 0/0/0/0/1",
               cpu_rd_valid_a, cpu_rd_data_a, mem_we_a, mem_addr_a, cpu_cmd_ready_a);
    else n_pass++;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      if (cpu_rd_valid_a !== 1'b0 || mem_we_a !== 1'b0) bad++;
      nc();
    end
    n_total++;
    if (bad != 0) $display("FAIL mid_reset_flush: got %0d bad cycles exp 0", bad);
    else n_pass++;
  endtask

  task automatic test_max_addr();
    logic prev_vga;
    logic exp_we;
    logic exp_rv;
    logic [7:0] exp_rd;
    logic [7:0] exp_vd;
    int bad;
    bad = 0;
    prev_vga = 1'b0;
    do_reset();
    vga_address = 19'h4AFFF;
    for (int k = 0; k < 12; k++) begin
      vga_rd_en = (k >= 1 && k <= 7 && (k % 2) == 1);
      cpu_cmd_valid = (k < 4);
      cpu_cmd_we    = (k == 0 || k == 2);
      cpu_cmd_addr  = 19'h4AFFF;
      cpu_cmd_wdata = (k == 0) ? 8'h5A : 8'hA5;
      #1;
      exp_we = (k == 2 || k == 6);
      exp_rv = (k == 6 || k == 10);
      exp_rd = (k == 6) ? 8'h5A : 8'hA5;
      exp_vd = (k == 2) ? 8'h00 : (k == 8) ? 8'hA5 : 8'h5A;
      n_total++;
      if (mem_we_a !== exp_we || vga_rdata_valid_a !== prev_vga)
        $display("FAIL max_k%0d: got we=%b vv=%b exp %b/%b", k,
                 mem_we_a, vga_rdata_valid_a, exp_we, prev_vga);
      else n_pass++;
      if (k >= 1 && mem_addr_a !== 19'h4AFFF) bad++;
      if (prev_vga && vga_rdata_a !== exp_vd) bad++;
      if (cpu_rd_valid_a !== exp_rv) bad++;
      if (exp_rv && cpu_rd_data_a !== exp_rd) bad++;
      prev_vga = vga_rd_en;
      nc();
    end
    n_total++;
    if (bad != 0) $display("FAIL max_data: got %0d bad values exp 0", bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_vga_priority();
    test_steal();
    test_full_drain();
    test_reset_midop();
    test_max_addr();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
